ro_freq_counter: RTL and testbench

Gated frequency counter that measures the on-chip ring oscillator output in the clk domain. The oscillator output enters asynchronously, is synchronized, and its rising edges are counted over a programmable window of clk cycles. The block sits beside the ring oscillator in the top-level wrapper. The latched result is read out in parallel, or byte-by-byte over the 8-bit dedicated outputs.

---
 rtl/ro_freq_counter.sv | 122 ++++++++++++
 tb/tb_ro_freq_counter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized osc_in rises over gate_len clk cycles.
// Result and done arrive gate_len+1 cycles after start is accepted; start is ignored while busy.
module ro_freq_counter #(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              osc_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [1:0]        byte_sel,
    output logic [CNT_W-1:0]  count,
    output logic [7:0]        count_byte,
    output logic              done,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               s1_q, s2_q, s3_q;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sat_q, sat_d;
    logic               ovf_q, ovf_d;
    logic               rise;
    logic               edge_max;
    logic [31:0]        count_ext;

    assign rise     = s2_q & ~s3_q;
    assign edge_max = &edge_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            count_q    <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_q       <= osc_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            count_q    <= count_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        count_d    = count_q;
        sat_d      = sat_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    if (gate_len != '0) begin
                        gate_cnt_d = gate_len;
                        state_d    = MEASURE;
                    end else begin
                        count_d = '0;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (edge_max) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end
                gate_cnt_d = gate_cnt_q - 1'b1;
                // Result registers load on the way into DONE so they are visible with done.
                if (gate_cnt_q == GATE_W'(1)) begin
                    count_d = edge_cnt_d;
                    ovf_d   = sat_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        count_ext              = '0;
        count_ext[CNT_W-1:0]   = count_q;
    end

    assign count_byte = count_ext[{byte_sel, 3'b000} +: 8];
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign done       = (state_q == DONE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: a 16-bit and an 8-bit instance driven by shared stimulus.
module tb_ro_freq_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        osc_in = 1'b0;
    logic        start = 1'b0;
    logic [15:0] gate_len = '0;
    logic [1:0]  byte_sel = '0;

    logic [15:0] count16;
    logic [7:0]  cb16;
    logic        done16, busy16, ovf16;
    logic [7:0]  count8;
    logic [7:0]  cb8;
    logic        done8, busy8, ovf8;

    int n_chk = 0;
    int n_pass = 0;
    int osc_hi = 0;
    int osc_lo = 0;
    int ph = 0;

    ro_freq_counter #(.CNT_W(16), .GATE_W(16)) dut16 (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .gate_len(gate_len),
        .byte_sel(byte_sel), .count(count16), .count_byte(cb16), .done(done16),
        .busy(busy16), .overflow(ovf16)
    );

    ro_freq_counter #(.CNT_W(8), .GATE_W(16)) dut8 (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .gate_len(gate_len),
        .byte_sel(byte_sel), .count(count8), .count_byte(cb8), .done(done8),
        .busy(busy8), .overflow(ovf8)
    );

    always #5 clk = ~clk;

    // Periodic oscillator: osc_hi cycles high, osc_lo cycles low; osc_hi==0 holds it low.
    always @(negedge clk) begin
        if (osc_hi == 0) begin
            osc_in = 1'b0;
            ph     = 0;
        end else begin
            if (ph >= osc_hi + osc_lo) ph = 0;
            osc_in = (ph < osc_hi);
            ph     = (ph + 1) % (osc_hi + osc_lo);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_rng(input string name, input logic [31:0] act, input int lo, input int hi);
        n_chk++;
        if (!$isunknown(act) && int'(act) >= lo && int'(act) <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic set_osc(input int hi, input int lo);
        osc_hi = hi;
        osc_lo = lo;
        repeat (10) @(negedge clk);
    endtask

    // Start a run from IDLE; returns cycle of done (-1 on timeout) and busy-cycle count.
    task automatic measure(input int n, output int dcyc, output int bcyc);
        int c;
        @(negedge clk);
        start    = 1'b1;
        gate_len = 16'(n);
        dcyc     = -1;
        bcyc     = 0;
        @(negedge clk);
        start = 1'b0;
        c     = 1;
        while (c <= n + 30) begin
            if (busy16) bcyc++;
            if (done16) begin
                dcyc = c;
                break;
            end
            @(negedge clk);
            c++;
        end
    endtask

    typedef struct {
        int gate;
        int hi;
        int lo;
        int lo16;
        int hi16;
        int lo8;
        int hi8;
        int ovf8;
    } vec_t;

    vec_t vt[7];

    initial begin
        int dcyc, bcyc, ndone, first, d1, d2;
        int hi, lo, n, p, elo, ehi;
        logic [7:0] exp_b16[4];
        logic [7:0] exp_b8[4];

        vt[0] = '{100,  0, 0,    0,    0,   0,   0, 0};
        vt[1] = '{1000, 5, 5,   99,  101,  99, 101, 0};
        vt[2] = '{0,    2, 2,    0,    0,   0,   0, 0};
        vt[3] = '{2000, 2, 2,  499,  501, 255, 255, 1};
        vt[4] = '{40,   2, 2,    9,   11,   9,  11, 0};
        vt[5] = '{1,    0, 0,    0,    0,   0,   0, 0};
        vt[6] = '{6000, 2, 2, 1500, 1500, 255, 255, 1};
        exp_b16 = '{8'hDC, 8'h05, 8'h00, 8'h00};
        exp_b8  = '{8'hFF, 8'h00, 8'h00, 8'h00};

        // Reset with osc toggling
        osc_hi = 1;
        osc_lo = 1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_count16", count16, 0);
        chk("rst_count8", count8, 0);
        chk("rst_done", done16, 0);
        chk("rst_busy", busy16, 0);
        chk("rst_ovf", ovf16, 0);
        chk("rst_byte", cb16, 0);
        rst = 1'b0;

        // Table-driven measurements
        for (int i = 0; i < 7; i++) begin
            set_osc(vt[i].hi, vt[i].lo);
            measure(vt[i].gate, dcyc, bcyc);
            chk($sformatf("v%0d_done_cyc", i), dcyc, vt[i].gate + 1);
            chk($sformatf("v%0d_busy_cyc", i), bcyc, vt[i].gate + 1);
            chk($sformatf("v%0d_done8", i), done8, 1);
            chk_rng($sformatf("v%0d_count16", i), count16, vt[i].lo16, vt[i].hi16);
            chk($sformatf("v%0d_ovf16", i), ovf16, 0);
            chk_rng($sformatf("v%0d_count8", i), count8, vt[i].lo8, vt[i].hi8);
            chk($sformatf("v%0d_ovf8", i), ovf8, vt[i].ovf8);
        end

        // Byte readout of 1500 (16-bit) and saturated 255 (8-bit)
        for (int b = 0; b < 4; b++) begin
            byte_sel = 2'(b);
            #1;
            chk($sformatf("byte16_%0d", b), cb16, exp_b16[b]);
            chk($sformatf("byte8_%0d", b), cb8, exp_b8[b]);
        end
        byte_sel = 2'd0;

        // start during MEASURE and at DONE is ignored; gate_len change mid-run has no effect
        set_osc(0, 0);
        @(negedge clk);
        start    = 1'b1;
        gate_len = 16'd50;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        first = -1;
        for (int c = 1; c <= 70; c++) begin
            if (done16) begin
                ndone++;
                if (first < 0) first = c;
            end
            if (c == 5) begin
                start    = 1'b1;
                gate_len = 16'd3;
            end else if (c == 6) begin
                start = 1'b0;
            end else if (c == first) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_done_cyc", first, 51);
        chk("ign_busy_end", busy16, 0);
        chk("ign_count", count16, 0);

        // start held high re-triggers on the cycle after DONE
        @(negedge clk);
        start    = 1'b1;
        gate_len = 16'd10;
        @(negedge clk);
        ndone = 0;
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done16) begin
                ndone++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) begin
                    d2 = c;
                    start = 1'b0;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("retrig_ndone", ndone, 2);
        chk("retrig_d1", d1, 11);
        chk("retrig_d2", d2, 23);

        // Reset mid-MEASURE after a non-zero result
        set_osc(2, 3);
        measure(50, dcyc, bcyc);
        chk("prerst_count", count16, 10);
        @(negedge clk);
        start    = 1'b1;
        gate_len = 16'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy16, 0);
        chk("abort_count", count16, 0);
        chk("abort_done", done16, 0);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 90; c++) begin
            if (done16 || done8) ndone++;
            @(negedge clk);
        end
        chk("abort_no_done", ndone, 0);
        measure(20, dcyc, bcyc);
        chk("post_rst_done_cyc", dcyc, 21);
        chk("post_rst_count", count16, 4);

        // Random periods and windows against the arithmetic edge-count model
        for (int r = 0; r < 8; r++) begin
            hi = $urandom_range(6, 1);
            lo = $urandom_range(6, 1);
            if (hi + lo < 3) lo = 2;
            n  = $urandom_range(1500, 1);
            p  = hi + lo;
            elo = (n / p > 0) ? n / p - 1 : 0;
            ehi = (n + p - 1) / p + 1;
            set_osc(hi, lo);
            measure(n, dcyc, bcyc);
            chk($sformatf("rnd%0d_done_cyc", r), dcyc, n + 1);
            chk_rng($sformatf("rnd%0d_count16", r), count16, elo, ehi);
            chk($sformatf("rnd%0d_ovf16", r), ovf16, 0);
            if (elo >= 256) begin
                chk($sformatf("rnd%0d_count8", r), count8, 255);
                chk($sformatf("rnd%0d_ovf8", r), ovf8, 1);
            end else if (ehi <= 255) begin
                chk_rng($sformatf("rnd%0d_count8", r), count8, elo, ehi);
                chk($sformatf("rnd%0d_ovf8", r), ovf8, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
